// File: rtl/wave_pkg.sv
// Shared types and constants for the wave sequencer: waveform codes, FSM states
// and the one-hot select patterns driven to the generator mux.
package wave_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  localparam logic [3:0] SW_OFF    = 4'b0000;
  localparam logic [3:0] SW_SINE   = 4'b0001;
  localparam logic [3:0] SW_SQUARE = 4'b0010;
  localparam logic [3:0] SW_SAW    = 4'b0100;
  localparam logic [3:0] SW_TRI    = 4'b1000;

  function automatic logic [3:0] wave_onehot(input wave_e w);
    logic [3:0] sel;
    sel = SW_OFF;
    case (w)
      WAVE_SINE:   sel = SW_SINE;
      WAVE_SQUARE: sel = SW_SQUARE;
      WAVE_SAW:    sel = SW_SAW;
      WAVE_TRI:    sel = SW_TRI;
      default:     sel = SW_OFF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wave_sequencer_if.sv
// Control, table-write and status signals of the wave sequencer, bundled for
// connection between a controller (master) and the sequencer (slave).
interface wave_sequencer_if #(
  parameter int unsigned steps_p     = 8,
  parameter int unsigned dur_width_p = 16
);

  localparam int unsigned AddrW = $clog2(steps_p);

  logic                   ready_i;
  logic                   start_i;
  logic                   stop_i;
  logic                   loop_i;
  logic [dur_width_p-1:0] gap_i;
  logic                   wr_en_i;
  logic [AddrW-1:0]       wr_addr_i;
  logic [1:0]             wr_wave_i;
  logic [dur_width_p-1:0] wr_dur_i;
  logic [3:0]             sw_o;
  logic                   gate_o;
  logic [AddrW-1:0]       step_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output ready_i, start_i, stop_i, loop_i, gap_i,
    output wr_en_i, wr_addr_i, wr_wave_i, wr_dur_i,
    input  sw_o, gate_o, step_o, busy_o, done_o
  );

  modport slave (
    input  ready_i, start_i, stop_i, loop_i, gap_i,
    input  wr_en_i, wr_addr_i, wr_wave_i, wr_dur_i,
    output sw_o, gate_o, step_o, busy_o, done_o
  );

endinterface

// File: rtl/seq_step_table.sv
// Step table: per-step waveform code and duration. One synchronous write port,
// one combinational read port; contents clear to (sine, 0) on reset.
module seq_step_table
  import wave_pkg::*;
#(
  parameter int unsigned steps_p     = 8,
  parameter int unsigned dur_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(steps_p)-1:0] wr_addr_i,
  input  wave_e                      wr_wave_i,
  input  logic [dur_width_p-1:0]     wr_dur_i,
  input  logic [$clog2(steps_p)-1:0] rd_addr_i,
  output wave_e                      rd_wave_o,
  output logic [dur_width_p-1:0]     rd_dur_o
);

  wave_e                  wave_r [steps_p];
  logic [dur_width_p-1:0] dur_r  [steps_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < steps_p; i++) begin
        wave_r[i] <= WAVE_SINE;
        dur_r[i]  <= '0;
      end
    end else if (wr_en_i) begin
      wave_r[wr_addr_i] <= wr_wave_i;
      dur_r[wr_addr_i]  <= wr_dur_i;
    end
  end

  assign rd_wave_o = wave_r[rd_addr_i];
  assign rd_dur_o  = dur_r[rd_addr_i];

endmodule

// File: rtl/wave_sequencer.sv
// Wave sequencer: steps through the step table, sounding each step for its
// duration in ready_i samples, optionally followed by a silent gap.
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int unsigned steps_p     = 8,
  parameter int unsigned dur_width_p = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  wave_sequencer_if.slave  bus
);

  localparam int unsigned                AddrW    = $clog2(steps_p);
  localparam logic [AddrW-1:0]           LastStep = AddrW'(steps_p - 1);
  localparam logic [AddrW-1:0]           StepOne  = AddrW'(1);
  localparam logic [dur_width_p-1:0]     CntOne   = dur_width_p'(1);

  state_e                 state_r, state_n;
  logic [AddrW-1:0]       step_r, step_n;
  logic [dur_width_p-1:0] cnt_r, cnt_n;
  logic [dur_width_p-1:0] dur_r, dur_n;
  logic [dur_width_p-1:0] gap_r, gap_n;
  wave_e                  wave_r, wave_n;
  logic                   done_r, done_n;
  logic                   advance;

  wave_e                  tbl_wave;
  logic [dur_width_p-1:0] tbl_dur;

  seq_step_table #(
    .steps_p     (steps_p),
    .dur_width_p (dur_width_p)
  ) u_step_table (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wr_en_i   (bus.wr_en_i),
    .wr_addr_i (bus.wr_addr_i),
    .wr_wave_i (wave_e'(bus.wr_wave_i)),
    .wr_dur_i  (bus.wr_dur_i),
    .rd_addr_i (step_r),
    .rd_wave_o (tbl_wave),
    .rd_dur_o  (tbl_dur)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      step_r  <= '0;
      cnt_r   <= '0;
      dur_r   <= '0;
      gap_r   <= '0;
      wave_r  <= WAVE_SINE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      step_r  <= step_n;
      cnt_r   <= cnt_n;
      dur_r   <= dur_n;
      gap_r   <= gap_n;
      wave_r  <= wave_n;
      done_r  <= done_n;
    end
  end

  // Counters compare against limit-1 so a full-scale duration never overflows;
  // dur_r and gap_r are always >= 1 whenever their state is active.
  always_comb begin
    state_n = state_r;
    step_n  = step_r;
    cnt_n   = cnt_r;
    dur_n   = dur_r;
    gap_n   = gap_r;
    wave_n  = wave_r;
    done_n  = 1'b0;
    advance = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_n = ST_LOAD;
          step_n  = '0;
        end
      end
      ST_LOAD: begin
        wave_n  = tbl_wave;
        dur_n   = (tbl_dur == '0) ? CntOne : tbl_dur;
        cnt_n   = '0;
        state_n = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.ready_i) begin
          if (cnt_r == dur_r - CntOne) begin
            cnt_n = '0;
            if (bus.gap_i != '0) begin
              gap_n   = bus.gap_i;
              state_n = ST_GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_n = cnt_r + CntOne;
          end
        end
      end
      ST_GAP: begin
        if (bus.ready_i) begin
          if (cnt_r == gap_r - CntOne) begin
            cnt_n   = '0;
            advance = 1'b1;
          end else begin
            cnt_n = cnt_r + CntOne;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (advance) begin
      if (step_r != LastStep) begin
        step_n  = step_r + StepOne;
        state_n = ST_LOAD;
      end else if (bus.loop_i) begin
        step_n  = '0;
        state_n = ST_LOAD;
      end else begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
    end

    // Abort overrides every transition above, including a same-cycle natural end.
    if (bus.stop_i) begin
      state_n = ST_IDLE;
      step_n  = '0;
      cnt_n   = '0;
      done_n  = 1'b0;
    end
  end

  always_comb begin
    bus.sw_o   = SW_OFF;
    bus.gate_o = 1'b0;
    if (state_r == ST_PLAY) begin
      bus.sw_o   = wave_onehot(wave_r);
      bus.gate_o = 1'b1;
    end
  end

  assign bus.step_o = step_r;
  assign bus.busy_o = (state_r != ST_IDLE);
  assign bus.done_o = done_r;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed scenarios plus randomized
// runs, each compared cycle by cycle against a segment-level playback model.
module tb_wave_sequencer;

  localparam int unsigned STEPS = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = $clog2(STEPS);
  localparam int          HMAX  = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_sequencer_if #(.steps_p(STEPS), .dur_width_p(DW)) bus ();

  wave_sequencer #(.steps_p(STEPS), .dur_width_p(DW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Shadow of the step table and parameters of the current run.
  int sh_wave [STEPS];
  int sh_dur  [STEPS];
  int r_gap, horizon, wr_cyc, wr_a, wr_w, wr_d;
  bit r_loop;
  bit rdy [HMAX];
  int e_sw [HMAX], e_gate [HMAX], e_step [HMAX], e_busy [HMAX], e_done [HMAX];

  function automatic void emit(input int t, input int busy, input int gate,
                               input int sw, input int step, input int done);
    if (t < horizon) begin
      e_busy[t] = busy; e_gate[t] = gate; e_sw[t] = sw;
      e_step[t] = step; e_done[t] = done;
    end
  endfunction

  // Cycle 0 carries start_i; each step is one load cycle, then `dur` ready
  // pulses sounding, then `gap` ready pulses silent.
  function automatic void build_model();
    int t, step, n, w, d;
    for (int i = 0; i < horizon; i++) emit(i, 0, 0, 0, 0, 0);
    t = 1;
    step = 0;
    while (t < horizon) begin
      w = sh_wave[step];
      d = sh_dur[step];
      if (wr_cyc >= 0 && wr_cyc < t && wr_a == step) begin
        w = wr_w;
        d = wr_d;
      end
      emit(t, 1, 0, 0, step, 0);
      t++;
      if (d == 0) d = 1;
      n = 0;
      while (n < d && t < horizon) begin
        emit(t, 1, 1, 1 << w, step, 0);
        if (rdy[t]) n++;
        t++;
      end
      n = 0;
      while (n < r_gap && t < horizon) begin
        emit(t, 1, 0, 0, step, 0);
        if (rdy[t]) n++;
        t++;
      end
      if (t >= horizon) break;
      if (step < int'(STEPS) - 1) step++;
      else if (r_loop) step = 0;
      else begin
        emit(t, 0, 0, 0, step, 1);
        t++;
        while (t < horizon) begin
          emit(t, 0, 0, 0, step, 0);
          t++;
        end
      end
    end
  endfunction

  task automatic write_step(input int a, input int w, input int d);
    @(negedge clk);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = AW'(a);
    bus.wr_wave_i = 2'(w);
    bus.wr_dur_i  = DW'(d);
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    sh_wave[a] = w;
    sh_dur[a]  = d;
  endtask

  // mode: 0 = ready every cycle, 1 = random ready, 2 = ready every 4th cycle.
  task automatic run_pattern(input string name, input int gap, input bit loop, input int mode,
                             input int hz, input bit rand_wr, input bit rand_start);
    int dut_done, mdl_done;
    r_gap   = gap;
    r_loop  = loop;
    horizon = hz;
    for (int t = 0; t < hz; t++)
      rdy[t] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (t % 4 == 0);
    wr_cyc = -1;
    if (rand_wr) begin
      wr_cyc = $urandom_range(1, hz / 2);
      wr_a   = $urandom_range(0, STEPS - 1);
      wr_w   = $urandom_range(0, 3);
      wr_d   = $urandom_range(0, 5);
    end
    build_model();
    bus.gap_i  = DW'(gap);
    bus.loop_i = loop;
    dut_done = 0;
    mdl_done = 0;
    for (int t = 0; t < hz; t++) begin
      @(negedge clk);
      check_eq($sformatf("%s busy t=%0d", name, t), 32'(bus.busy_o), e_busy[t]);
      check_eq($sformatf("%s gate t=%0d", name, t), 32'(bus.gate_o), e_gate[t]);
      check_eq($sformatf("%s sw t=%0d", name, t), 32'(bus.sw_o), e_sw[t]);
      check_eq($sformatf("%s done t=%0d", name, t), 32'(bus.done_o), e_done[t]);
      if (t > 0) check_eq($sformatf("%s step t=%0d", name, t), 32'(bus.step_o), e_step[t]);
      dut_done += int'(bus.done_o);
      mdl_done += e_done[t];
      bus.ready_i = rdy[t];
      bus.start_i = (t == 0) || (rand_start && e_busy[t] != 0 && $urandom_range(0, 2) == 0);
      bus.wr_en_i = (t == wr_cyc);
      if (t == wr_cyc) begin
        bus.wr_addr_i = AW'(wr_a);
        bus.wr_wave_i = 2'(wr_w);
        bus.wr_dur_i  = DW'(wr_d);
      end
    end
    check_eq($sformatf("%s done_count", name), 32'(dut_done), 32'(mdl_done));
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.stop_i  = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    check_eq($sformatf("%s stop busy", name), 32'(bus.busy_o), 0);
    check_eq($sformatf("%s stop gate", name), 32'(bus.gate_o), 0);
    check_eq($sformatf("%s stop sw", name), 32'(bus.sw_o), 0);
    check_eq($sformatf("%s stop step", name), 32'(bus.step_o), 0);
    check_eq($sformatf("%s stop done", name), 32'(bus.done_o), 0);
    if (wr_cyc >= 0) begin
      sh_wave[wr_a] = wr_w;
      sh_dur[wr_a]  = wr_d;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, " sw"}, 32'(bus.sw_o), 0);
    check_eq({name, " gate"}, 32'(bus.gate_o), 0);
    check_eq({name, " step"}, 32'(bus.step_o), 0);
    check_eq({name, " busy"}, 32'(bus.busy_o), 0);
    check_eq({name, " done"}, 32'(bus.done_o), 0);
  endtask

  initial begin
    bus.ready_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.loop_i = 1'b0;
    bus.gap_i = '0; bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_wave_i = '0; bus.wr_dur_i = '0;
    for (int i = 0; i < int'(STEPS); i++) begin
      sh_wave[i] = 0;
      sh_dur[i]  = 0;
    end

    @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    write_step(0, 0, 3);
    write_step(1, 1, 2);
    run_pattern("basic", 0, 1'b0, 0, 20, 1'b0, 1'b0);
    run_pattern("gap", 2, 1'b0, 0, 24, 1'b0, 1'b0);
    run_pattern("loop", 0, 1'b1, 0, 24, 1'b0, 1'b0);

    write_step(0, 2, 1);
    write_step(1, 3, 200);
    run_pattern("stop_play", 0, 1'b1, 0, 10, 1'b0, 1'b1);

    write_step(0, 3, 0);
    write_step(1, 2, 0);
    run_pattern("sparse", 0, 1'b0, 2, 20, 1'b0, 1'b0);
    run_pattern("sparse_gap", 1, 1'b1, 2, 40, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      for (int a = 0; a < int'(STEPS); a++)
        write_step(a, $urandom_range(0, 3), $urandom_range(0, 5));
      run_pattern($sformatf("rand%0d", k), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 120, 1'b1, 1'b1);
    end

    write_step(0, 2, 4);
    write_step(1, 3, 4);
    @(negedge clk);
    bus.loop_i  = 1'b1;
    bus.gap_i   = '0;
    bus.ready_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midreset busy_before", 32'(bus.busy_o), 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset async");
    for (int i = 0; i < int'(STEPS); i++) begin
      sh_wave[i] = 0;
      sh_dur[i]  = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("midreset idle busy %0d", i), 32'(bus.busy_o), 0);
      check_eq($sformatf("midreset idle gate %0d", i), 32'(bus.gate_o), 0);
    end
    bus.ready_i = 1'b0;
    run_pattern("cleared_table", 0, 1'b0, 0, 16, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter steps_p, default 8, meaning number of pattern steps (power of two, >=2).
REQ-002 SHALL have parameter dur_width_p, default 16, meaning width of the per-step duration and gap counters, in samples.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ready_i  input  1  sample strobe; one pulse is one output sample consumed.
REQ-006 SHALL have port start_i  input  1  single-cycle request to begin playback at step 0.
REQ-007 SHALL have port stop_i  input  1  single-cycle request to abort playback.
REQ-008 SHALL have port loop_i  input  1  when 1, the pattern wraps from step steps_p-1 back to step 0.
REQ-009 SHALL have port gap_i  input  dur_width_p  count of silent samples inserted after every step.
REQ-010 SHALL have port wr_en_i  input  1  step-table write enable.
REQ-011 SHALL have port wr_addr_i  input  $clog2(steps_p)  step-table write address.
REQ-012 SHALL have port wr_wave_i  input  2  waveform code: 0 = sine, 1 = square, 2 = sawtooth, 3 = triangle.
REQ-013 SHALL have port wr_dur_i  input  dur_width_p  step duration in samples.
REQ-014 SHALL have port sw_o  output  4  one-hot waveform select for the generator mux (0001 sine, 0010 square, 0100 sawtooth, 1000 triangle; 0000 = silence).
REQ-015 SHALL have port gate_o  output  1  high while a step is sounding.
REQ-016 SHALL have port step_o  output  $clog2(steps_p)  index of the current step.
REQ-017 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done_o  output  1  single-cycle pulse on natural end of a non-looping pattern.

Function
REQ-019 SHALL implement an FSM with states IDLE, LOAD, PLAY and GAP.
REQ-020 SHALL move from IDLE to LOAD on start_i, with step index set to 0; start_i SHALL be ignored in every other state.
REQ-021 SHALL, in LOAD, register wave and duration of the current step and move to PLAY on the next cycle (start to gate_o high latency = 2 cycles).
REQ-022 SHALL, in PLAY, drive gate_o=1 and sw_o as the one-hot of the registered wave code.
REQ-023 SHALL, in PLAY, increment the sample counter only on cycles with ready_i=1.
REQ-024 SHALL leave PLAY on the ready_i pulse that makes the counter equal the duration.
REQ-025 SHALL treat a duration of 0 as 1.
REQ-026 SHALL, on leaving PLAY, go to GAP if gap_i is nonzero, else advance directly (REQ-028).
REQ-027 SHALL, in GAP, drive gate_o=0 and sw_o=0000, and count gap_i ready_i pulses, with gap_i sampled on entry to GAP.
REQ-028 SHALL advance as follows: if step < steps_p-1, increment the step and go to LOAD; at the last step with loop_i=1, set step 0 and go to LOAD; at the last step with loop_i=0, go to IDLE and pulse done_o for one cycle.
REQ-029 SHALL give stop_i priority over every other event: on the next edge go to IDLE, clear gate_o, sw_o, step_o and counters, and assert no done_o.
REQ-030 SHALL make table writes take effect on the next edge; a write to the currently playing step SHALL not alter it until that step is next loaded.
REQ-031 SHALL count correctly with ready_i held high continuously (one sample per cycle).

Reset
REQ-032 SHALL, on reset_n_i low, immediately force state IDLE, sw_o=0000, gate_o=0, step_o=0, busy_o=0, done_o=0 and counters to 0.
REQ-033 SHALL reset step-table contents to wave 0 and duration 0.
REQ-034 SHALL, when reset is asserted mid-playback, not resume playback after release until a new start_i.

Structure
REQ-035 SHALL place the wave-code enum, the FSM state enum and the one-hot select constants in shared package wave_pkg.
REQ-036 SHALL hold the step table in sub-module seq_step_table (register file, one write port, one combinational read port).

Verification
REQ-037 SHALL verify basic playback: steps 0/1 = (sine, 3), (square, 2), gap_i=0, loop_i=0, steps_p=2, ready_i every cycle -> sw_o 0001 for 3 samples, then 0010 for 2, then done_o once and busy_o low.
REQ-038 SHALL verify the gap: gap_i=2 in the REQ-037 setup -> after each step, gate_o=0 and sw_o=0000 for exactly 2 ready_i pulses.
REQ-039 SHALL verify looping: loop_i=1 -> step_o sequence 0,1,0,1 and no done_o.
REQ-040 SHALL verify stop and start: stop_i while in PLAY -> IDLE next cycle, all outputs 0; start_i while busy -> ignored.
REQ-041 SHALL verify sparse ready_i and zero duration: ready_i every 4th cycle with duration 0 -> step lasts exactly one ready_i pulse.
REQ-042 SHALL verify reset mid-playback: reset_n_i low -> outputs 0 asynchronously; after release, stays in IDLE.
